pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator for the IO fabric, the next generation of the fabric's single 8-bit free-running RGB/general PWM. It provides CHANNELS outputs from one shared programmable-period counter with edge-aligned or center-aligned counting. Per-channel duty and the period are written through a simple register port into shadow registers. Shadow values transfer to the active set only at a period boundary, so output pulses never glitch mid-period.

---
 rtl/pwm_bank.sv | 107 ++++++++++
 tb/tb_pwm_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM bank with shared period counter and shadowed duty/period registers
// Edge- or center-aligned counting; shadows transfer to the active set only when the next count is 0.
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    localparam int AW      = $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                center,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [CNT_W-1:0]    duty_sh_q  [CHANNELS];
    logic [CNT_W-1:0]    duty_act_q [CHANNELS];
    logic [CNT_W-1:0]    per_sh_q, per_act_q;
    logic                mode_q;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic [CHANNELS-1:0] wr_duty;
    logic                wr_per;
    logic                boundary;

    always_comb begin
        wr_per = wr_en && (wr_addr == AW'(CHANNELS));
        for (int i = 0; i < CHANNELS; i++) begin
            wr_duty[i] = wr_en && (wr_addr == AW'(i));
        end
    end

    // dir_q=1 means counting down; only ever set in center mode
    always_comb begin
        cnt_d = '0;
        dir_d = 1'b0;
        if (enable) begin
            if (!mode_q) begin
                cnt_d = (cnt_q >= per_act_q) ? '0 : cnt_q + 1'b1;
            end else if (!dir_q) begin
                if (cnt_q >= per_act_q) begin
                    cnt_d = (per_act_q == '0) ? '0 : per_act_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            dir_d = mode_q && (cnt_d != '0) && (dir_q || (cnt_q >= per_act_q));
        end
    end

    // a disabled bank yields cnt_d=0, so every idle cycle is a boundary
    assign boundary = (cnt_d == '0);

    always_comb begin
        tick_d = enable && (cnt_q == '0);
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < duty_act_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            per_sh_q  <= '1;
            per_act_q <= '1;
            mode_q    <= 1'b0;
            pwm_q     <= '0;
            tick_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
            if (wr_per) begin
                per_sh_q <= wr_data;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_duty[i]) begin
                    duty_sh_q[i] <= wr_data;
                end
            end
            if (boundary) begin
                per_act_q <= wr_per ? wr_data : per_sh_q;
                mode_q    <= center;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act_q[i] <= wr_duty[i] ? wr_data : duty_sh_q[i];
                end
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed vector table plus hand sequences for pwm_bank (CHANNELS=4, CNT_W=8)
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       center = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] pwm_out;
    logic       period_tick;

    int errors = 0;
    int checks = 0;

    pwm_bank #(.CHANNELS(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .center      (center),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ctr;
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [3:0] pwm;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int en, int c, int we, int a, int d, int p, int t);
        vec_t v;
        v.rst  = r[0];
        v.en   = en[0];
        v.ctr  = c[0];
        v.we   = we[0];
        v.addr = a[2:0];
        v.data = d[7:0];
        v.pwm  = p[3:0];
        v.tick = t[0];
        return v;
    endfunction

    // drive one cycle of inputs, then sample the registered outputs just after the edge
    task automatic step(input logic r, input logic en, input logic c, input logic we,
                        input logic [2:0] a, input logic [7:0] d);
        rst = r; enable = en; center = c; wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got tick/pwm=%b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // rst en ctr we addr data | pwm tick
        vecs.push_back(mk(1,0,0,0,0,0,   4'h0,0));
        vecs.push_back(mk(0,0,0,1,4,3,   4'h0,0));
        vecs.push_back(mk(0,0,0,1,0,2,   4'h0,0));
        vecs.push_back(mk(0,0,0,1,2,4,   4'h0,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h5,1));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h5,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h5,1));
        vecs.push_back(mk(0,1,0,1,0,3,   4'h5,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,0,1,1,1,   4'h4,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h7,1));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h5,0));
        vecs.push_back(mk(0,1,0,1,5,1,   4'h5,0));
        vecs.push_back(mk(0,1,0,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,1,1,4,4,   4'h7,1));
        vecs.push_back(mk(0,1,1,1,0,2,   4'h5,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h5,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h7,1));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h5,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h0,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h4,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h5,0));
        vecs.push_back(mk(0,1,1,0,0,0,   4'h7,1));

        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].en, vecs[k].ctr, vecs[k].we, vecs[k].addr, vecs[k].data);
            check($sformatf("vec%0d", k), {period_tick, pwm_out}, {vecs[k].tick, vecs[k].pwm});
        end

        // P=0, edge mode: every enabled cycle is a new period
        step(0, 0, 0, 1, 3'd4, 8'd0);
        check("p0_disabled", {period_tick, pwm_out}, 5'b0_0000);
        step(0, 0, 0, 1, 3'd0, 8'd1);
        for (int j = 0; j < 8; j++) begin
            step(0, 1, 0, 0, 3'd0, 8'd0);
            check($sformatf("p0_cyc%0d", j), {period_tick, pwm_out}, 5'b1_0111);
        end

        // P=254 with D=255 stays high; D=0 stays low
        step(0, 0, 0, 1, 3'd4, 8'd254);
        step(0, 0, 0, 1, 3'd0, 8'd255);
        step(0, 0, 0, 1, 3'd2, 8'd0);
        for (int j = 0; j < 300; j++) begin
            step(0, 1, 0, 0, 3'd0, 8'd0);
            check($sformatf("full_cyc%0d", j), {3'b000, pwm_out[2], pwm_out[0]}, 5'b00001);
        end

        // reset mid-run at P=3; the simultaneous write must be lost
        step(0, 0, 0, 1, 3'd4, 8'd3);
        for (int j = 0; j < 5; j++) begin
            step(0, 1, 0, 0, 3'd0, 8'd0);
        end
        step(1, 1, 0, 1, 3'd0, 8'd5);
        check("rst_outputs", {period_tick, pwm_out}, 5'b0_0000);
        for (int j = 0; j < 600; j++) begin
            step(0, 1, 0, 0, 3'd0, 8'd0);
            check($sformatf("post_rst_cyc%0d", j), {period_tick, pwm_out},
                  {((j % 256) == 0) ? 1'b1 : 1'b0, 4'b0000});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
